// File: rtl/instruction_prefetch.sv
// Sequential 32-bit instruction prefetcher: one outstanding memory fetch, DEPTH-entry {pc,instr} buffer, valid/ready to CPU.
// Latency: ack in cycle N is visible at o_valid in N+1; request drops for the full cycle the buffer is full; redirect flushes.
module instruction_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  output logic                     o_mem_req,
  output logic [15:0]              o_mem_address,
  input  logic                     i_mem_ack,
  input  logic [31:0]              i_mem_data,
  output logic                     o_valid,
  output logic [31:0]              o_instruction,
  output logic [15:0]              o_pc,
  input  logic                     i_ready,
  input  logic                     i_redirect,
  input  logic [15:0]              i_redirect_pc,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [15:0]     fetch_pc;
  logic            full;
  logic            push;
  logic            pop;

  // Full is judged on registered count only, so a same-cycle pop never re-enables the request.
  assign full          = (count == CW'(DEPTH));
  assign o_mem_req     = i_reset_n && !i_redirect && !full;
  assign o_mem_address = fetch_pc;
  assign push          = o_mem_req && i_mem_ack;
  assign pop           = o_valid && i_ready;

  assign o_valid       = (count != '0);
  assign head          = mem[rd_ptr];
  assign o_instruction = o_valid ? head.instr : '0;
  assign o_pc          = o_valid ? head.pc    : '0;
  assign o_count       = count;

  // Storage needs no reset: entries are only observable while count is non-zero.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= {fetch_pc, i_mem_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (i_redirect) begin
      fetch_pc <= i_redirect_pc & 16'hFFFC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PW'(1);
        fetch_pc <= fetch_pc + 16'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule
